// File: rtl/comm_slave_if.sv
// Core-side handshake bundle for the comm_slave command/response endpoint.
interface comm_slave_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;
  logic        frame_err;

  modport slave (
    output cmd, cmd_rdy, tx_busy, resp_sent, frame_err,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport master (
    input  cmd, cmd_rdy, tx_busy, resp_sent, frame_err,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/comm_slave.sv
// Far-end endpoint of the two-byte UART command link: 8N1 RX engine,
// high/low byte assembler with inter-byte timeout, and 8N1 response TX engine.
//
// state         | meaning
// RX_IDLE       | line idle, waiting for a 1->0 edge
// RX_START      | counting to start-bit centre, reject glitches
// RX_DATA       | sampling 8 data bits, LSB first
// RX_STOP       | sampling stop bit, emits byte_valid or frame_err
// AS_WAIT_HIGH  | waiting for the command high byte
// AS_WAIT_LOW   | high byte held, timeout running, waiting for low byte
// TX_IDLE       | line high, may accept send_resp
// TX_START      | driving start bit
// TX_DATA       | driving 8 data bits, LSB first
// TX_STOP       | driving stop bit
module comm_slave #(
  parameter int BAUD_DIV = 2604,
  parameter int TIMEOUT  = 52080
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  RX,
  output logic  TX,
  comm_slave_if.slave bus
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {AS_WAIT_HIGH, AS_WAIT_LOW} as_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic rx_s1, rx_s2, rx_prev;
  rx_state_t rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          byte_valid, frame_err_q;
  logic          rx_fall, rx_tick;

  as_state_t as_state, as_state_nxt;
  logic [7:0]    hi_byte;
  logic [TW-1:0] to_cnt;
  logic [15:0]   cmd_q;
  logic          cmd_rdy_q, cmd_done;

  tx_state_t tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_q, busy_q, sent_q;
  logic          tx_accept, tx_tick;

  assign rx_fall   = rx_prev & ~rx_s2;
  assign rx_tick   = (rx_cnt == CW'(1));
  assign tx_tick   = (tx_cnt == CW'(1));
  assign tx_accept = (tx_state == TX_IDLE) && !busy_q && bus.send_resp;
  assign cmd_done  = (as_state == AS_WAIT_LOW) && byte_valid;

  // Two-flop synchronizer on RX plus one more stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  // RX engine next-state logic.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
      RX_START: if (rx_tick) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX bit timing, data shift and stop-bit strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      byte_valid  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (rx_fall) begin
          rx_cnt <= BAUD_HALF;
          rx_bit <= '0;
        end
      end else if (rx_tick) begin
        rx_cnt <= BAUD_FULL;
        if (rx_state == RX_DATA) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
        end
        if (rx_state == RX_STOP) begin
          byte_valid  <= rx_s2;
          frame_err_q <= ~rx_s2;
        end
      end else begin
        rx_cnt <= rx_cnt - CW'(1);
      end
    end
  end

  // Assembler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) as_state <= AS_WAIT_HIGH;
    else        as_state <= as_state_nxt;
  end

  // Assembler next-state: low byte, timeout expiry or a bad frame all end WAIT_LOW.
  always_comb begin
    as_state_nxt = as_state;
    case (as_state)
      AS_WAIT_HIGH: if (byte_valid) as_state_nxt = AS_WAIT_LOW;
      AS_WAIT_LOW:  if (byte_valid || frame_err_q || to_cnt == TW'(1))
                      as_state_nxt = AS_WAIT_HIGH;
      default:      as_state_nxt = AS_WAIT_HIGH;
    endcase
  end

  // High-byte capture, timeout down-counter and command/ready registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_byte   <= '0;
      to_cnt    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      if (as_state == AS_WAIT_HIGH && byte_valid) begin
        hi_byte <= rx_shift;
        to_cnt  <= TO_LOAD;
      end else if (as_state == AS_WAIT_LOW) begin
        to_cnt <= to_cnt - TW'(1);
      end
      if (cmd_done) begin
        cmd_q     <= {hi_byte, rx_shift};
        cmd_rdy_q <= 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end
    end
  end

  // TX engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  // TX engine next-state logic.
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_accept) tx_state_nxt = TX_START;
      TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX datapath; line, busy and done are registered one cycle behind the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      tx_q   <= (tx_state == TX_START) ? 1'b0 :
                (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
      busy_q <= (tx_state != TX_IDLE);
      sent_q <= busy_q && (tx_state == TX_IDLE);
      if (tx_accept) begin
        tx_shift <= bus.resp;
        tx_cnt   <= BAUD_FULL;
        tx_bit   <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= BAUD_FULL;
          if (tx_state == TX_DATA) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt - CW'(1);
        end
      end
    end
  end

  assign TX            = tx_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.tx_busy   = busy_q;
  assign bus.resp_sent = sent_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_comm_slave.sv
// Self-checking bench for comm_slave: directed link scenarios plus randomized
// byte streams against a timestamp-based model of the command protocol.
module tb_comm_slave;
  localparam int B    = 16;
  localparam int TO   = 400;
  localparam int SOFF = 3 + B / 2 + 9 * B;  // stop-bit sample edge after frame start drive

  logic clk, rst_n, rx, tx;
  comm_slave_if bus ();

  comm_slave #(.BAUD_DIV(B), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .RX   (rx),
    .TX   (tx),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fe_cnt  = 0;
  int rs_cnt  = 0;
  bit seen_5577 = 0;

  logic [15:0] exp_cmd;
  bit          exp_rdy;
  bit          pend_v;
  logic [7:0]  pend_b;
  int          pend_t;
  int          exp_fe = 0;
  int          exp_rs = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.resp_sent === 1'b1) rs_cnt++;
    if (bus.cmd === 16'h5577) seen_5577 = 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame; check the stop-sample cycle and the cycle after it.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit clr_hit);
    logic [9:0]  fb;
    bit          comp;
    logic [15:0] nxt_cmd;
    fb      = {stop_bit, b, 1'b0};
    comp    = 0;
    nxt_cmd = exp_cmd;
    for (int i = 0; i < 10 * B; i++) begin
      @(posedge clk);
      #1;
      if (i % B == 0) rx = fb[i / B];
      if (i == SOFF) begin
        chk("frame_err_at_stop", bus.frame_err, !stop_bit);
        chk("cmd_before_done", bus.cmd, exp_cmd);
        if (stop_bit) begin
          if (pend_v && (cyc - pend_t) <= TO) begin
            comp    = 1;
            nxt_cmd = {pend_b, b};
            pend_v  = 0;
          end else begin
            pend_v = 1;
            pend_b = b;
            pend_t = cyc;
          end
        end else begin
          pend_v = 0;
          exp_fe++;
        end
        if (clr_hit) bus.clr_cmd_rdy = 1;
      end
      if (i == SOFF + 1) begin
        bus.clr_cmd_rdy = 0;
        if (comp) exp_rdy = 1;
        else if (clr_hit) exp_rdy = 0;
        exp_cmd = nxt_cmd;
        chk("frame_err_after", bus.frame_err, 1'b0);
        chk("cmd_after", bus.cmd, exp_cmd);
        chk("cmd_rdy_after", bus.cmd_rdy, exp_rdy);
      end
    end
    if (!stop_bit) begin
      rx = 1;
      repeat (B) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 bus.clr_cmd_rdy = 1;
    @(posedge clk);
    #1 bus.clr_cmd_rdy = 0;
    exp_rdy = 0;
    chk("clr_rdy", bus.cmd_rdy, 1'b0);
    chk("clr_cmd_hold", bus.cmd, exp_cmd);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Request a response and check the full TX waveform cycle by cycle.
  task automatic tx_frame(input logic [7:0] b, input bit poke);
    logic [9:0] fb;
    logic       exp_tx;
    fb = {1'b1, b, 1'b0};
    @(posedge clk);
    #1;
    bus.resp      = b;
    bus.send_resp = 1;
    @(posedge clk);
    #1;
    bus.send_resp = 0;
    bus.resp      = 8'($urandom);
    chk("tx_t0_line", tx, 1'b1);
    chk("tx_t0_busy", bus.tx_busy, 1'b0);
    for (int t = 1; t <= 10 * B + 2; t++) begin
      @(posedge clk);
      #1;
      if (poke && t == 50) begin
        bus.resp      = 8'hFF;
        bus.send_resp = 1;
      end
      if (poke && t == 51) bus.send_resp = 0;
      exp_tx = (t <= 10 * B) ? fb[(t - 1) / B] : 1'b1;
      chk("tx_line", tx, exp_tx);
      chk("tx_busy", bus.tx_busy, (t <= 10 * B));
      chk("resp_sent", bus.resp_sent, (t == 10 * B + 1));
    end
    exp_rs++;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         g;
    rx              = 1;
    rst_n           = 1;
    bus.clr_cmd_rdy = 0;
    bus.send_resp   = 0;
    bus.resp        = 8'h00;
    exp_cmd = 16'h0000;
    exp_rdy = 0;
    pend_v  = 0;
    pend_b  = 8'h00;
    pend_t  = 0;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_cmd", bus.cmd, 16'h0000);
    chk("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
    chk("rst_tx_busy", bus.tx_busy, 1'b0);
    chk("rst_resp_sent", bus.resp_sent, 1'b0);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    rst_n = 1;
    idle(5);

    send_byte(8'hA5, 1, 0);
    send_byte(8'h3C, 1, 0);
    chk("cmd_a53c", bus.cmd, 16'hA53C);
    chk("no_frame_err_a53c", fe_cnt, 0);
    pulse_clr();
    chk("clr_keeps_a53c", bus.cmd, 16'hA53C);

    idle(7);
    send_byte(8'h12, 1, 0);
    send_byte(8'h34, 1, 1);
    chk("set_wins_cmd", bus.cmd, 16'h1234);
    chk("set_wins_rdy", bus.cmd_rdy, 1'b1);

    idle(3);
    send_byte(8'h55, 1, 0);
    idle(401);
    send_byte(8'h77, 1, 0);
    send_byte(8'h88, 1, 0);
    chk("cmd_7788", bus.cmd, 16'h7788);
    chk("no_5577", seen_5577, 1'b0);

    send_byte(8'hF0, 0, 0);
    chk("fe_count_f0", fe_cnt, 1);
    send_byte(8'h01, 1, 0);
    send_byte(8'h02, 1, 0);
    chk("cmd_0102", bus.cmd, 16'h0102);

    send_byte(8'h33, 1, 0);
    send_byte(8'h44, 0, 0);
    send_byte(8'h05, 1, 0);
    send_byte(8'h06, 1, 0);
    chk("cmd_0506", bus.cmd, 16'h0506);

    pulse_clr();
    @(posedge clk);
    #1 rx = 0;
    repeat (3) @(posedge clk);
    #1 rx = 1;
    idle(40);
    chk("glitch_fe", fe_cnt, exp_fe);
    chk("glitch_cmd", bus.cmd, exp_cmd);
    chk("glitch_rdy", bus.cmd_rdy, 1'b0);
    send_byte(8'h11, 1, 0);
    send_byte(8'h22, 1, 0);
    chk("cmd_1122", bus.cmd, 16'h1122);

    send_byte(8'h9A, 1, 0);
    idle(TO - 10 * B);
    send_byte(8'hBC, 1, 0);
    chk("timeout_edge_ok", bus.cmd, 16'h9ABC);
    send_byte(8'hDE, 1, 0);
    idle(TO - 10 * B + 1);
    send_byte(8'hF1, 1, 0);
    chk("timeout_edge_drop", bus.cmd, 16'h9ABC);

    for (int k = 0; k < 16; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      g  = (k % 3 == 0) ? 0 : int'($urandom_range(0, 300));
      if (exp_rdy && $urandom_range(0, 1) == 1) pulse_clr();
      idle(g);
      send_byte(rb, rs, ($urandom_range(0, 3) == 0));
    end
    chk("rand_cmd_final", bus.cmd, exp_cmd);

    idle(5);
    tx_frame(8'hC3, 1);
    idle(4);
    chk("resp_count_c3", rs_cnt, 1);
    for (int k = 0; k < 2; k++) tx_frame(8'($urandom), 0);

    pend_v = 0;
    idle(TO + 5);
    fork
      tx_frame(8'($urandom), 0);
      begin
        idle(23);
        send_byte(8'h6B, 1, 0);
        send_byte(8'hD4, 1, 0);
      end
    join
    chk("cmd_during_tx", bus.cmd, 16'h6BD4);

    idle(3);
    @(posedge clk);
    #1;
    bus.resp      = 8'h81;
    bus.send_resp = 1;
    @(posedge clk);
    #1 bus.send_resp = 0;
    repeat (40) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("midframe_rst_tx", tx, 1'b1);
    chk("midframe_rst_busy", bus.tx_busy, 1'b0);
    chk("midframe_rst_cmd", bus.cmd, 16'h0000);
    chk("midframe_rst_rdy", bus.cmd_rdy, 1'b0);
    exp_cmd = 16'h0000;
    exp_rdy = 0;
    pend_v  = 0;
    @(posedge clk);
    #2 rst_n = 1;
    idle(4);
    send_byte(8'hDE, 1, 0);
    send_byte(8'hAD, 1, 0);
    chk("cmd_after_rst", bus.cmd, 16'hDEAD);

    idle(20);
    chk("frame_err_total", fe_cnt, exp_fe);
    chk("resp_sent_total", rs_cnt, exp_rs);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
